// File: rtl/odo_sbox_pkg.sv
// Shared definitions for the Odo small S-box blocks: width and loader FSM states.
package odo_sbox_pkg;

    localparam int unsigned ODO_SBOX_SMALL_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_ERROR = 2'd3
    } odo_sbox_state_e;

endpackage

// File: rtl/odo_sbox_inv_mem.sv
// N x W inverse table: one synchronous write port, one registered read port.
module odo_sbox_inv_mem #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [W-1:0] raddr,
    output logic [W-1:0] rdata
);

    localparam int unsigned N = 1 << W;

    logic [W-1:0] mem [N];

    // Table storage is deliberately left unreset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/odo_sbox_inv_loader.sv
// Builds S^-1 from a streamed forward S-box table and serves 1-cycle inverse lookups.
// Optional bijection check enabled by ODO_SBOX_INV_CHECK_EN.
module odo_sbox_inv_loader
    import odo_sbox_pkg::*;
#(
    parameter int unsigned W = ODO_SBOX_SMALL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_start,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         load_ready,
    output logic         table_ready,
    output logic         table_err,
    input  logic         lk_valid,
    input  logic [W-1:0] lk_in,
    output logic         lk_out_valid,
    output logic [W-1:0] lk_out
);

    localparam int unsigned N = 1 << W;

    odo_sbox_state_e state_q;
    logic [W-1:0]    idx_q;
    logic            beat_c;
    logic            last_c;
    logic            lk_en_c;
    logic            dup_c;

    // load_start wins over a coincident load_valid, so that beat never writes.
    assign beat_c  = (state_q == ST_LOAD) && load_valid && !load_start;
    assign last_c  = beat_c && (idx_q == W'(N - 1));
    assign lk_en_c = lk_valid && (state_q == ST_READY);

`ifdef ODO_SBOX_INV_CHECK_EN
    logic [N-1:0] seen_q;
    logic         dup_q;

    // Seen bitmap and sticky duplicate flag for the bijection check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
            dup_q  <= 1'b0;
        end else if (load_start) begin
            seen_q <= '0;
            dup_q  <= 1'b0;
        end else if (beat_c) begin
            seen_q[load_data] <= 1'b1;
            if (seen_q[load_data]) begin
                dup_q <= 1'b1;
            end
        end
    end

    assign dup_c = dup_q || (beat_c && seen_q[load_data]);
`else
    assign dup_c = 1'b0;
`endif

    // Loader FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            load_ready   <= 1'b0;
            table_ready  <= 1'b0;
            table_err    <= 1'b0;
            lk_out_valid <= 1'b0;
        end else begin
            lk_out_valid <= lk_en_c;
            if (load_start) begin
                state_q     <= ST_LOAD;
                idx_q       <= '0;
                load_ready  <= 1'b1;
                table_ready <= 1'b0;
                table_err   <= 1'b0;
            end else if (beat_c) begin
                idx_q <= idx_q + W'(1);
                if (last_c) begin
                    state_q     <= dup_c ? ST_ERROR : ST_READY;
                    load_ready  <= 1'b0;
                    table_ready <= !dup_c;
                    table_err   <= dup_c;
                end
            end
        end
    end

    odo_sbox_inv_mem #(
        .W(W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat_c),
        .waddr (load_data),
        .wdata (idx_q),
        .re    (lk_en_c),
        .raddr (lk_in),
        .rdata (lk_out)
    );

endmodule
